// File: rtl/kypd_scan_ctrl_pkg.sv
// Shared types and constants for the keypad scanner slice.
package kypd_pkg;

    // Whole-keypad sweep classification
    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } kypd_class_e;

    // Ceiling log2 for sizing counters and pointers
    function automatic int unsigned kypd_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Digilent 4x4 keypad: code (row*4+col) to hex legend
    //   row 0: 1 2 3 A / row 1: 4 5 6 B / row 2: 7 8 9 C / row 3: 0 F E D
    localparam logic [15:0][3:0] KYPD_HEX_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] kypd_hex(input logic [3:0] code);
        return KYPD_HEX_MAP[code];
    endfunction

endpackage

// File: rtl/kypd_scan_ctrl_if.sv
// Key event read channel: head-of-FIFO code with valid/ready handshake.
interface kypd_scan_ctrl_if #(
    parameter int unsigned CW = 4
);
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/kypd_scan_ctrl_event_fifo.sv
// Small key-event FIFO: valid/ready read side, drop-on-full write side
// with a sticky overflow flag.
module kypd_event_fifo
    import kypd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    input  logic             ovf_clr,
    output logic             overflow
);
    localparam int unsigned AW = (DEPTH > 1) ? kypd_clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Occupancy from wrap-bit pointers; a pop frees the slot a full push needs
    always_comb begin
        rd_valid = (wr_ptr != rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop   = rd_valid && rd_ready;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
    end

    // Pointer and sticky overflow update; a drop beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kypd_scan_ctrl.sv
// Keypad scanner: column drive, row synchronisation, sweep classification,
// whole-sweep debounce and key-press event generation into a FIFO.
module kypd_scan_ctrl
    import kypd_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 4,
    parameter int unsigned DWELL_CYC      = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_COLS-1:0] col_drive,
    input  logic [NUM_ROWS-1:0] row_sense,
    kypd_scan_ctrl_if.master    kif,
    output logic                key_held,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int unsigned NK   = NUM_ROWS * NUM_COLS;
    localparam int unsigned CW   = kypd_clog2(NK);
    localparam int unsigned DWW  = (DWELL_CYC > 1) ? kypd_clog2(DWELL_CYC) : 1;
    localparam int unsigned COLW = (NUM_COLS > 1) ? kypd_clog2(NUM_COLS) : 1;
    localparam int unsigned SCW  = kypd_clog2(DEBOUNCE_SCANS + 1);

    logic [NUM_ROWS-1:0] row_s1;
    logic [NUM_ROWS-1:0] row_s2;
    logic [DWW-1:0]      dwell_cnt;
    logic [COLW-1:0]     col_idx;
    logic [NK-1:0]       scan_vec;
    logic [NK-1:0]       sweep_vec;
    logic                last_dwell;
    logic                sweep_end;

    logic [CW:0]         key_cnt;
    logic [CW-1:0]       key_pos;
    kypd_class_e         cls;
    logic [CW-1:0]       cls_code;

    kypd_class_e         prev_class;
    logic [CW-1:0]       prev_code;
    logic [SCW-1:0]      stab_cnt;
    logic [SCW-1:0]      stab_nxt;
    kypd_class_e         stable_class;
    logic [CW-1:0]       stable_code;
    logic                same;
    logic                accept;
    logic                push_nxt;
    logic                push_pend;

    // Two-flop synchroniser for the asynchronous active-low rows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_sense;
            row_s2 <= row_s1;
        end
    end

    // Active-low one-cold column drive from the current column index
    always_comb begin
        col_drive          = '1;
        col_drive[col_idx] = 1'b0;
    end

    // Sweep image including the column being captured this cycle, then classify
    always_comb begin
        last_dwell = (dwell_cnt == DWW'(DWELL_CYC - 1));
        sweep_end  = last_dwell && (col_idx == COLW'(NUM_COLS - 1));
        sweep_vec  = scan_vec;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            sweep_vec[CW'(r * NUM_COLS) + CW'(col_idx)] = ~row_s2[r];
        end
        key_cnt = '0;
        key_pos = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (sweep_vec[i]) begin
                key_cnt = key_cnt + (CW+1)'(1);
                key_pos = CW'(i);
            end
        end
        if (key_cnt == '0) begin
            cls = CLS_NONE;
        end else if (key_cnt == (CW+1)'(1)) begin
            cls = CLS_ONE;
        end else begin
            cls = CLS_MULTI;
        end
        cls_code = (cls == CLS_ONE) ? key_pos : '0;
    end

    // Dwell counter, column rotation and per-column row capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
            scan_vec  <= '0;
        end else if (last_dwell) begin
            dwell_cnt <= '0;
            scan_vec  <= sweep_vec;
            col_idx   <= (col_idx == COLW'(NUM_COLS - 1)) ? '0 : col_idx + COLW'(1);
        end else begin
            dwell_cnt <= dwell_cnt + DWW'(1);
        end
    end

    // Debounce run length and press-event decision at sweep end
    always_comb begin
        same = (cls == prev_class) && (cls_code == prev_code);
        if (!same) begin
            stab_nxt = SCW'(1);
        end else if (stab_cnt == SCW'(DEBOUNCE_SCANS)) begin
            stab_nxt = stab_cnt;
        end else begin
            stab_nxt = stab_cnt + SCW'(1);
        end
        accept   = (stab_nxt == SCW'(DEBOUNCE_SCANS)) &&
                   ((cls != stable_class) || (cls_code != stable_code));
        push_nxt = sweep_end && accept && (cls == CLS_ONE) &&
                   (stable_class != CLS_MULTI);
    end

    // Debounce state, one-cycle-delayed push request and held indication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_class   <= CLS_NONE;
            prev_code    <= '0;
            stab_cnt     <= '0;
            stable_class <= CLS_NONE;
            stable_code  <= '0;
            push_pend    <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            push_pend <= push_nxt;
            key_held  <= (stable_class == CLS_ONE);
            if (sweep_end) begin
                prev_class <= cls;
                prev_code  <= cls_code;
                stab_cnt   <= stab_nxt;
                if (accept) begin
                    stable_class <= cls;
                    stable_code  <= cls_code;
                end
            end
        end
    end

    // stable_code still holds the accepted code during the push cycle
    kypd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_pend),
        .push_data (stable_code),
        .rd_data   (kif.key_code),
        .rd_valid  (kif.key_valid),
        .rd_ready  (kif.key_ready),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Bench for kypd_scan_ctrl: keypad matrix model, sweep-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_kypd_scan_ctrl;
    import kypd_pkg::*;

    localparam int unsigned NR    = 4;
    localparam int unsigned NC    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEB   = 3;
    localparam int unsigned FD    = 2;
    localparam int          SWEEP = 16;
    localparam int          MULTI = 99;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] col_drive;
    logic [NR-1:0] row_sense;
    logic          key_held;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic [15:0]   pressed = '0;

    int compared   = 0;
    int mismatched = 0;

    kypd_scan_ctrl_if #(.CW(4)) kif ();

    kypd_scan_ctrl #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .DWELL_CYC      (DW),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_drive (col_drive),
        .row_sense (row_sense),
        .kif       (kif),
        .key_held  (key_held),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_sense = '1;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (pressed[r*NC+c] && (col_drive[c] === 1'b0)) row_sense[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: -1 = no key, 0..15 = single key code, MULTI = several keys
    int  m_cyc = 0;
    bit  m_ok = 1'b0;
    int  m_q[$];
    bit  m_ovf, m_held, m_pend;
    int  m_pend_code;
    int  m_stab;
    int  hist[$];

    function automatic int classify(input logic [15:0] p);
        int n;
        int pos;
        n   = 0;
        pos = -1;
        for (int i = 0; i < 16; i++) begin
            if (p[i]) begin
                n++;
                pos = i;
            end
        end
        if (n == 0) return -1;
        if (n > 1)  return MULTI;
        return pos;
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_col;
        bit   drop;
        bit   held_n;
        bit   pend_n;
        bit   all_same;
        int   cls;
        if (m_ok) begin
            exp_col = ~(4'b0001 << ((m_cyc / DW) % NC));
            check("col_drive", col_drive, exp_col);
            check("key_valid", kif.key_valid, m_q.size() > 0);
            check("key_code", kif.key_code, (m_q.size() > 0) ? m_q[0] : 0);
            check("key_held", key_held, m_held);
            check("overflow", overflow, m_ovf);
        end
        if (rst_n !== 1'b1) begin
            m_q.delete();
            hist.delete();
            m_ovf  = 0;
            m_held = 0;
            m_pend = 0;
            m_stab = -1;
            m_cyc  = 0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            drop   = 0;
            held_n = (m_stab >= 0) && (m_stab < 16);
            if ((m_q.size() > 0) && kif.key_ready) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() < FD) m_q.push_back(m_pend_code);
                else drop = 1;
            end
            if (ovf_clr) m_ovf = 0;
            if (drop)    m_ovf = 1;
            pend_n = 0;
            if ((m_cyc % SWEEP) == SWEEP - 1) begin
                cls = classify(pressed);
                hist.push_back(cls);
                if (hist.size() > DEB) void'(hist.pop_front());
                all_same = (hist.size() == DEB);
                foreach (hist[i]) if (hist[i] != cls) all_same = 0;
                if (all_same && (cls != m_stab)) begin
                    if ((cls >= 0) && (cls < 16) && (m_stab != MULTI)) begin
                        pend_n      = 1;
                        m_pend_code = cls;
                    end
                    m_stab = cls;
                end
            end
            m_held = held_n;
            m_pend = pend_n;
            m_cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        for (int i = 0; (i < SWEEP + 1) && ((m_cyc % SWEEP) != 0); i++) tick(1);
    endtask

    task automatic sweeps(input int n);
        tick(n * SWEEP);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while ((kif.key_valid !== 1'b1) && (n < budget)) begin
            tick(1);
            n++;
        end
        check(name, kif.key_valid, 1);
    endtask

    task automatic pop_one();
        kif.key_ready = 1'b1;
        tick(1);
        kif.key_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_ready = 1'b0;
        tick(3);
        // 1: reset values and column rotation
        check("rst_col", col_drive, 4'b1110);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", overflow, 0);
        check("rst_code", kif.key_code, 0);
        rst_n = 1'b1;
        tick(4);  check("col_step1", col_drive, 4'b1101);
        tick(4);  check("col_step2", col_drive, 4'b1011);
        tick(4);  check("col_step3", col_drive, 4'b0111);
        tick(4);  check("col_wrap", col_drive, 4'b1110);

        // 2: hold key 9, one event only, release clears held
        align();
        pressed = 16'h0001 << 9;
        wait_valid("k9_valid", 3 * SWEEP + 4);
        check("k9_code", kif.key_code, 9);
        check("k9_held", key_held, 1);
        align();
        sweeps(20);
        check("k9_still_one", kif.key_code, 9);
        pop_one();
        check("k9_single_event", kif.key_valid, 0);
        align();
        pressed = '0;
        sweeps(4);
        check("k9_release_held", key_held, 0);

        // 3: bouncing key 6 never settles
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 2 == 0) ? (16'h0001 << 6) : 16'h0000;
            sweeps(1);
        end
        pressed = '0;
        sweeps(4);
        check("bounce_no_event", kif.key_valid, 0);

        // 4: multi-key rejection, no event on MULTI -> ONE
        pressed = (16'h0001 << 0) | (16'h0001 << 5);
        sweeps(4);
        check("multi_held", key_held, 0);
        check("multi_no_event", kif.key_valid, 0);
        pressed = 16'h0001 << 5;
        sweeps(4);
        check("multi_to_one_no_event", kif.key_valid, 0);
        check("multi_to_one_held", key_held, 1);
        pressed = '0;
        sweeps(4);
        check("multi_release_held", key_held, 0);
        pressed = 16'h0001 << 5;
        wait_valid("k5_valid", 3 * SWEEP + 4);
        check("k5_code", kif.key_code, 5);
        pop_one();
        align();
        pressed = '0;
        sweeps(4);

        // 5: FIFO full, overflow sticky, drain and clear
        for (int k = 1; k <= 3; k++) begin
            pressed = 16'h0001 << k;
            sweeps(4);
            pressed = '0;
            sweeps(4);
        end
        check("ovf_valid", kif.key_valid, 1);
        check("ovf_head", kif.key_code, 1);
        check("ovf_set", overflow, 1);
        kif.key_ready = 1'b1;
        tick(1);
        check("ovf_second", kif.key_code, 2);
        tick(1);
        kif.key_ready = 1'b0;
        check("ovf_drained", kif.key_valid, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // 6: mid-operation reset discards pending event
        align();
        pressed = 16'h0001 << 4;
        sweeps(3);
        wait_valid("k4_valid", 8);
        check("k4_code", kif.key_code, 4);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_valid", kif.key_valid, 0);
        check("mid_rst_col", col_drive, 4'b1110);
        pressed = '0;
        rst_n = 1'b1;
        sweeps(4);
        check("post_rst_empty", kif.key_valid, 0);
        pressed = 16'h0001 << 7;
        wait_valid("k7_valid", 3 * SWEEP + 4);
        check("k7_code", kif.key_code, 7);
        pop_one();
        check("k7_single_event", kif.key_valid, 0);
        align();
        pressed = '0;
        sweeps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
